mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/lc3_mem_pkg.sv | 35 +++
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_watchdog.sv | 26 ++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types for the LC-3 memory arbiter: data-port access modes, arbiter
// FSM states and bus-owner encodings.
package lc3_mem_pkg;

    typedef enum logic [2:0] {
        READ_MEM        = 3'd0,
        READ_MEM_INDIR  = 3'd1,
        WRITE_MEM       = 3'd2,
        INIT_STATE      = 3'd3,
        WRITE_MEM_INDIR = 3'd4
    } mem_state_t;

    typedef enum logic [2:0] {
        IDLE,
        I_ACC,
        D_RD,
        D_PTR,
        D_IND,
        D_WR,
        DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_INSTR = 2'd1,
        OWNER_DATA  = 2'd2
    } owner_t;

    // States in which the memory is being driven and mem_rdy is meaningful.
    function automatic logic is_access(arb_state_t s);
        return (s == I_ACC) || (s == D_RD) || (s == D_PTR) ||
               (s == D_IND) || (s == D_WR);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and memory-side bus of the arbiter. The arbiter
// uses the slave modport; the CPU/memory side uses master.
interface mem_arbiter_if;

    logic        i_req;
    logic [15:0] i_addr;
    logic        complete_instr;
    logic [15:0] i_rdata;

    logic        d_req;
    logic [2:0]  d_mode;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        complete_data;
    logic [15:0] d_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_rdy;

    logic [1:0]  owner;
    logic        mem_err;

    modport slave (
        input  i_req, i_addr, d_req, d_mode, d_addr, d_wdata, mem_dout, mem_rdy,
        output complete_instr, i_rdata, complete_data, d_rdata,
               mem_en, mem_we, mem_addr, mem_din, owner, mem_err
    );

    modport master (
        output i_req, i_addr, d_req, d_mode, d_addr, d_wdata, mem_dout, mem_rdy,
        input  complete_instr, i_rdata, complete_data, d_rdata,
               mem_en, mem_we, mem_addr, mem_din, owner, mem_err
    );

endinterface

// File: rtl/mem_watchdog.sv
// Per-phase cycle counter; expired is high in the TIMEOUT_CYCLES-th cycle
// since the last clear. Saturates until cleared again.
module mem_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (!expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, with
// indirect modes. Define MEM_TIMEOUT_EN to abort stalled phases via mem_watchdog.
module mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_t  state_q, state_d;
    owner_t      owner_q;
    logic [2:0]  mode_q;
    logic [15:0] mem_addr_q;
    logic [15:0] mem_din_q;
    logic [15:0] i_rdata_q;
    logic [15:0] d_rdata_q;
    logic        mem_err_q;
    logic        timeout;

`ifdef MEM_TIMEOUT_EN
    logic wd_expired;

    // Any state change starts a fresh phase, so the count restarts there.
    mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_d != state_q),
        .expired (wd_expired)
    );

    assign timeout = wd_expired && is_access(state_q);
`else
    assign timeout = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.d_req) begin
                    case (bus.d_mode)
                        READ_MEM:                        state_d = D_RD;
                        READ_MEM_INDIR, WRITE_MEM_INDIR: state_d = D_PTR;
                        WRITE_MEM:                       state_d = D_WR;
                        default:                         state_d = DONE;
                    endcase
                end else if (bus.i_req) begin
                    state_d = I_ACC;
                end
            end
            I_ACC, D_RD, D_IND, D_WR: begin
                if (bus.mem_rdy || timeout) state_d = DONE;
            end
            D_PTR: begin
                if (bus.mem_rdy)    state_d = D_IND;
                else if (timeout)   state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: synchronous reset lives inside the clocked block, and all state
    // uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWNER_NONE;
            mode_q     <= 3'd0;
            mem_addr_q <= 16'h0000;
            mem_din_q  <= 16'h0000;
            i_rdata_q  <= 16'h0000;
            d_rdata_q  <= 16'h0000;
            mem_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.d_req) begin
                        owner_q    <= OWNER_DATA;
                        mode_q     <= bus.d_mode;
                        mem_addr_q <= bus.d_addr;
                        mem_din_q  <= bus.d_wdata;
                    end else if (bus.i_req) begin
                        owner_q    <= OWNER_INSTR;
                        mem_addr_q <= bus.i_addr;
                    end
                end
                I_ACC: begin
                    if (bus.mem_rdy) begin
                        i_rdata_q <= bus.mem_dout;
                    end else if (timeout) begin
                        i_rdata_q <= 16'h0000;
                        mem_err_q <= 1'b1;
                    end
                end
                D_RD: begin
                    if (bus.mem_rdy) begin
                        d_rdata_q <= bus.mem_dout;
                    end else if (timeout) begin
                        d_rdata_q <= 16'h0000;
                        mem_err_q <= 1'b1;
                    end
                end
                D_PTR: begin
                    // The pointer becomes the address of the second phase.
                    if (bus.mem_rdy) begin
                        mem_addr_q <= bus.mem_dout;
                    end else if (timeout) begin
                        mem_err_q <= 1'b1;
                        if (mode_q == READ_MEM_INDIR) d_rdata_q <= 16'h0000;
                    end
                end
                D_IND: begin
                    if (bus.mem_rdy) begin
                        if (mode_q == READ_MEM_INDIR) d_rdata_q <= bus.mem_dout;
                    end else if (timeout) begin
                        mem_err_q <= 1'b1;
                        if (mode_q == READ_MEM_INDIR) d_rdata_q <= 16'h0000;
                    end
                end
                D_WR: begin
                    if (!bus.mem_rdy && timeout) mem_err_q <= 1'b1;
                end
                DONE:    owner_q <= OWNER_NONE;
                default: ;
            endcase
        end
    end

    assign bus.mem_en         = is_access(state_q);
    assign bus.mem_we         = (state_q == D_WR) ||
                                ((state_q == D_IND) && (mode_q == WRITE_MEM_INDIR));
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_din        = mem_din_q;
    assign bus.complete_instr = (state_q == DONE) && (owner_q == OWNER_INSTR);
    assign bus.complete_data  = (state_q == DONE) && (owner_q == OWNER_DATA);
    assign bus.i_rdata        = i_rdata_q;
    assign bus.d_rdata        = d_rdata_q;
    assign bus.owner          = owner_q;
    assign bus.mem_err        = mem_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural memory with configurable wait
// states answers the bus; each scenario task checks its own expectations.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model: mem_rdy after rdy_wait stalled cycles of one phase.
    logic [15:0] mem_model [0:65535];
    int          rdy_wait  = 0;
    logic        rdy_force = 1'b0;
    int          wait_cnt  = 0;

    assign bus.mem_rdy  = (bus.mem_en && (wait_cnt >= rdy_wait)) || rdy_force;
    assign bus.mem_dout = mem_model[bus.mem_addr];

    int          cnt_ci = 0;
    int          cnt_cd = 0;
    int          en_cycles = 0;
    int          wr_count = 0;
    int          acc_n = 0;
    int          stab_err = 0;
    logic [15:0] acc_log [0:63];
    logic [15:0] last_wr_addr = 16'h0000;
    logic [15:0] last_wr_data = 16'h0000;
    logic        prev_hold = 1'b0;
    logic [15:0] prev_addr = 16'h0000;
    logic [15:0] prev_din  = 16'h0000;
    logic        prev_we   = 1'b0;

    always @(posedge clk) begin
        if (!bus.mem_en || bus.mem_rdy) wait_cnt <= 0;
        else                            wait_cnt <= wait_cnt + 1;
        if (bus.complete_instr) cnt_ci <= cnt_ci + 1;
        if (bus.complete_data)  cnt_cd <= cnt_cd + 1;
        if (bus.mem_en)         en_cycles <= en_cycles + 1;
        if (bus.mem_en && bus.mem_rdy) begin
            if (acc_n < 64) acc_log[acc_n] <= bus.mem_addr;
            acc_n <= acc_n + 1;
            if (bus.mem_we) begin
                wr_count     <= wr_count + 1;
                last_wr_addr <= bus.mem_addr;
                last_wr_data <= bus.mem_din;
            end
        end
        if (prev_hold && (bus.mem_en !== 1'b1 || bus.mem_addr !== prev_addr ||
                          bus.mem_din !== prev_din || bus.mem_we !== prev_we))
            stab_err <= stab_err + 1;
        prev_hold <= bus.mem_en && !bus.mem_rdy && !rst;
        prev_addr <= bus.mem_addr;
        prev_din  <= bus.mem_din;
        prev_we   <= bus.mem_we;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus.mem_en, bus.mem_we, bus.complete_instr, bus.complete_data, bus.mem_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {bus.mem_en, bus.mem_we, bus.complete_instr, bus.complete_data, bus.mem_err});
        end
        n_checks++;
        if (bus.owner !== 2'd0) begin
            n_fail++; $display("FAIL reset_owner: got %0d expected 0", bus.owner);
        end
        n_checks++;
        if ({bus.mem_addr, bus.mem_din, bus.i_rdata, bus.d_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h expected all 0000",
                     bus.mem_addr, bus.mem_din, bus.i_rdata, bus.d_rdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        int ci0;
        ci0 = cnt_ci;
        mem_model[16'h3000] = 16'h1261;
        rdy_wait   = 0;
        bus.i_addr = 16'h3000;
        bus.i_req  = 1'b1;
        n_checks++;
        if (bus.owner !== 2'd0) begin
            n_fail++; $display("FAIL fetch_idle_owner: got %0d expected 0", bus.owner);
        end
        tick();
        n_checks++;
        if (bus.owner !== 2'd1 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h3000) begin
            n_fail++;
            $display("FAIL fetch_access: got owner=%0d en=%b we=%b addr=%h expected 1 1 0 3000",
                     bus.owner, bus.mem_en, bus.mem_we, bus.mem_addr);
        end
        tick();
        n_checks++;
        if (bus.complete_instr !== 1'b1 || bus.complete_data !== 1'b0 || bus.i_rdata !== 16'h1261) begin
            n_fail++;
            $display("FAIL fetch_done: got ci=%b cd=%b i_rdata=%h expected 1 0 1261",
                     bus.complete_instr, bus.complete_data, bus.i_rdata);
        end
        n_checks++;
        if (bus.owner !== 2'd1 || bus.mem_en !== 1'b0) begin
            n_fail++; $display("FAIL fetch_done_owner: got owner=%0d en=%b expected 1 0", bus.owner, bus.mem_en);
        end
        bus.i_req = 1'b0;
        tick();
        n_checks++;
        if (bus.complete_instr !== 1'b0 || bus.owner !== 2'd0 || bus.i_rdata !== 16'h1261) begin
            n_fail++;
            $display("FAIL fetch_after: got ci=%b owner=%0d i_rdata=%h expected 0 0 1261",
                     bus.complete_instr, bus.owner, bus.i_rdata);
        end
        n_checks++;
        if (cnt_ci - ci0 !== 1) begin
            n_fail++; $display("FAIL fetch_pulses: got %0d expected 1", cnt_ci - ci0);
        end
    endtask

    task automatic test_priority();
        int ci0, cd0;
        ci0 = cnt_ci;
        cd0 = cnt_cd;
        mem_model[16'h4000] = 16'hA5A5;
        mem_model[16'h3002] = 16'h1234;
        bus.i_addr = 16'h3002;
        bus.d_addr = 16'h4000;
        bus.d_mode = 3'd0;
        bus.i_req  = 1'b1;
        bus.d_req  = 1'b1;
        tick();
        n_checks++;
        if (bus.owner !== 2'd2 || bus.mem_addr !== 16'h4000) begin
            n_fail++; $display("FAIL prio_data_first: got owner=%0d addr=%h expected 2 4000", bus.owner, bus.mem_addr);
        end
        tick();
        n_checks++;
        if (bus.complete_data !== 1'b1 || bus.complete_instr !== 1'b0 || bus.d_rdata !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL prio_data_done: got cd=%b ci=%b d_rdata=%h expected 1 0 a5a5",
                     bus.complete_data, bus.complete_instr, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        tick();
        n_checks++;
        if (bus.owner !== 2'd0 || bus.mem_en !== 1'b0) begin
            n_fail++; $display("FAIL prio_idle_gap: got owner=%0d en=%b expected 0 0", bus.owner, bus.mem_en);
        end
        tick();
        n_checks++;
        if (bus.owner !== 2'd1 || bus.mem_addr !== 16'h3002) begin
            n_fail++; $display("FAIL prio_fetch_grant: got owner=%0d addr=%h expected 1 3002", bus.owner, bus.mem_addr);
        end
        tick();
        n_checks++;
        if (bus.complete_instr !== 1'b1 || bus.complete_data !== 1'b0 || bus.i_rdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL prio_fetch_done: got ci=%b cd=%b i_rdata=%h expected 1 0 1234",
                     bus.complete_instr, bus.complete_data, bus.i_rdata);
        end
        bus.i_req = 1'b0;
        tick();
        n_checks++;
        if (cnt_ci - ci0 !== 1 || cnt_cd - cd0 !== 1) begin
            n_fail++; $display("FAIL prio_pulses: got ci=%0d cd=%0d expected 1 1", cnt_ci - ci0, cnt_cd - cd0);
        end
    endtask

    task automatic test_indirect_read();
        int cd0, a0;
        cd0 = cnt_cd;
        a0  = acc_n;
        mem_model[16'h5000] = 16'h6000;
        mem_model[16'h6000] = 16'hBEEF;
        bus.d_mode = 3'd1;
        bus.d_addr = 16'h5000;
        bus.d_req  = 1'b1;
        tick();
        n_checks++;
        if (bus.mem_addr !== 16'h5000 || bus.mem_we !== 1'b0 || bus.complete_data !== 1'b0) begin
            n_fail++; $display("FAIL ind_rd_ptr: got addr=%h we=%b cd=%b expected 5000 0 0", bus.mem_addr, bus.mem_we, bus.complete_data);
        end
        tick();
        n_checks++;
        if (bus.mem_addr !== 16'h6000 || bus.mem_en !== 1'b1 || bus.complete_data !== 1'b0) begin
            n_fail++; $display("FAIL ind_rd_target: got addr=%h en=%b cd=%b expected 6000 1 0", bus.mem_addr, bus.mem_en, bus.complete_data);
        end
        tick();
        n_checks++;
        if (bus.complete_data !== 1'b1 || bus.d_rdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL ind_rd_done: got cd=%b d_rdata=%h expected 1 beef", bus.complete_data, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        tick();
        n_checks++;
        if (cnt_cd - cd0 !== 1 || acc_n - a0 !== 2) begin
            n_fail++; $display("FAIL ind_rd_counts: got pulses=%0d accesses=%0d expected 1 2", cnt_cd - cd0, acc_n - a0);
        end
        n_checks++;
        if (acc_log[a0] !== 16'h5000 || acc_log[a0+1] !== 16'h6000) begin
            n_fail++; $display("FAIL ind_rd_addrs: got %h %h expected 5000 6000", acc_log[a0], acc_log[a0+1]);
        end
    endtask

    task automatic test_indirect_write();
        int  w0, a0, cycles;
        logic seen;
        w0 = wr_count;
        a0 = acc_n;
        mem_model[16'h5010] = 16'h7000;
        rdy_wait    = 2;
        bus.d_mode  = 3'd4;
        bus.d_addr  = 16'h5010;
        bus.d_wdata = 16'h00AA;
        bus.d_req   = 1'b1;
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            cycles++;
            seen = bus.complete_data;
        end
        n_checks++;
        if (!seen || cycles !== 7) begin
            n_fail++; $display("FAIL ind_wr_latency: got seen=%b cycles=%0d expected 1 7", seen, cycles);
        end
        n_checks++;
        if (bus.d_rdata !== 16'hBEEF || bus.mem_err !== 1'b0) begin
            n_fail++; $display("FAIL ind_wr_rdata: got d_rdata=%h err=%b expected beef 0", bus.d_rdata, bus.mem_err);
        end
        bus.d_req = 1'b0;
        rdy_wait  = 0;
        tick();
        n_checks++;
        if (wr_count - w0 !== 1 || last_wr_addr !== 16'h7000 || last_wr_data !== 16'h00AA) begin
            n_fail++;
            $display("FAIL ind_wr_write: got n=%0d addr=%h din=%h expected 1 7000 00aa",
                     wr_count - w0, last_wr_addr, last_wr_data);
        end
        n_checks++;
        if (acc_n - a0 !== 2 || acc_log[a0] !== 16'h5010) begin
            n_fail++; $display("FAIL ind_wr_ptr: got n=%0d first=%h expected 2 5010", acc_n - a0, acc_log[a0]);
        end
        n_checks++;
        if (stab_err !== 0) begin
            n_fail++; $display("FAIL bus_stable: got %0d changes while stalled expected 0", stab_err);
        end
    endtask

    task automatic test_direct_write();
        int w0;
        w0 = wr_count;
        bus.d_mode  = 3'd2;
        bus.d_addr  = 16'h8000;
        bus.d_wdata = 16'h5A5A;
        bus.d_req   = 1'b1;
        tick();
        n_checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_din !== 16'h5A5A || bus.mem_addr !== 16'h8000 || bus.owner !== 2'd2) begin
            n_fail++;
            $display("FAIL wr_access: got we=%b din=%h addr=%h owner=%0d expected 1 5a5a 8000 2",
                     bus.mem_we, bus.mem_din, bus.mem_addr, bus.owner);
        end
        tick();
        n_checks++;
        if (bus.complete_data !== 1'b1 || bus.mem_we !== 1'b0 || bus.d_rdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL wr_done: got cd=%b we=%b d_rdata=%h expected 1 0 beef", bus.complete_data, bus.mem_we, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        tick();
        n_checks++;
        if (wr_count - w0 !== 1 || last_wr_addr !== 16'h8000) begin
            n_fail++; $display("FAIL wr_count: got %0d at %h expected 1 at 8000", wr_count - w0, last_wr_addr);
        end
    endtask

    task automatic test_noop();
        int cd0, e0;
        logic [2:0] modes [2];
        modes[0] = 3'd3;
        modes[1] = 3'd7;
        for (int m = 0; m < 2; m++) begin
            cd0 = cnt_cd;
            e0  = en_cycles;
            bus.d_mode = modes[m];
            bus.d_addr = 16'h9000;
            bus.d_req  = 1'b1;
            tick();
            n_checks++;
            if (bus.complete_data !== 1'b1 || bus.mem_en !== 1'b0 || bus.owner !== 2'd2 || bus.d_rdata !== 16'hBEEF) begin
                n_fail++;
                $display("FAIL noop_mode%0d: got cd=%b en=%b owner=%0d d_rdata=%h expected 1 0 2 beef",
                         modes[m], bus.complete_data, bus.mem_en, bus.owner, bus.d_rdata);
            end
            bus.d_req = 1'b0;
            tick();
            n_checks++;
            if (cnt_cd - cd0 !== 1 || en_cycles - e0 !== 0) begin
                n_fail++;
                $display("FAIL noop_counts%0d: got pulses=%0d en_cycles=%0d expected 1 0",
                         modes[m], cnt_cd - cd0, en_cycles - e0);
            end
        end
    endtask

    task automatic test_rdy_ignored();
        int ci0, cd0;
        ci0 = cnt_ci;
        cd0 = cnt_cd;
        rdy_force = 1'b1;
        repeat (3) tick();
        rdy_force = 1'b0;
        tick();
        n_checks++;
        if (bus.owner !== 2'd0 || bus.mem_en !== 1'b0 || cnt_ci != ci0 || cnt_cd != cd0) begin
            n_fail++;
            $display("FAIL rdy_idle: got owner=%0d en=%b pulses=%0d expected 0 0 0",
                     bus.owner, bus.mem_en, (cnt_ci - ci0) + (cnt_cd - cd0));
        end
    endtask

    task automatic test_reset_mid_access();
        int cd0;
        cd0 = cnt_cd;
        bus.d_mode = 3'd1;
        bus.d_addr = 16'h5000;
        bus.d_req  = 1'b1;
        tick();
        tick();
        rdy_wait = 1000;
        tick();
        tick();
        n_checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h6000 || bus.owner !== 2'd2) begin
            n_fail++; $display("FAIL rst_stall: got en=%b addr=%h owner=%0d expected 1 6000 2", bus.mem_en, bus.mem_addr, bus.owner);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (bus.mem_en !== 1'b0 || bus.owner !== 2'd0 || bus.complete_data !== 1'b0 || bus.mem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_abort: got en=%b owner=%0d cd=%b addr=%h expected 0 0 0 0000",
                     bus.mem_en, bus.owner, bus.complete_data, bus.mem_addr);
        end
        rst       = 1'b0;
        bus.d_req = 1'b0;
        rdy_wait  = 0;
        tick();
        tick();
        n_checks++;
        if (cnt_cd - cd0 !== 0 || bus.mem_en !== 1'b0) begin
            n_fail++; $display("FAIL rst_no_pulse: got pulses=%0d en=%b expected 0 0", cnt_cd - cd0, bus.mem_en);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int   e0, cycles;
        logic seen;
        bus.d_mode = 3'd0;
        bus.d_addr = 16'h4000;
        bus.d_req  = 1'b1;
        tick();
        tick();
        bus.d_req = 1'b0;
        tick();
        n_checks++;
        if (bus.d_rdata !== 16'hA5A5) begin
            n_fail++; $display("FAIL to_preload: got %h expected a5a5", bus.d_rdata);
        end
        e0       = en_cycles;
        rdy_wait = 1000;
        bus.d_req = 1'b1;
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            cycles++;
            seen = bus.complete_data;
        end
        n_checks++;
        if (!seen || cycles !== 17 || en_cycles - e0 !== 16) begin
            n_fail++;
            $display("FAIL to_latency: got seen=%b cycles=%0d access=%0d expected 1 17 16",
                     seen, cycles, en_cycles - e0);
        end
        n_checks++;
        if (bus.mem_err !== 1'b1 || bus.d_rdata !== 16'h0000) begin
            n_fail++; $display("FAIL to_error: got err=%b d_rdata=%h expected 1 0000", bus.mem_err, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        rdy_wait  = 0;
        tick();
        n_checks++;
        if (bus.mem_err !== 1'b0) begin
            n_fail++; $display("FAIL to_err_clear: got %b expected 0", bus.mem_err);
        end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        bus.i_req   = 1'b0;
        bus.i_addr  = 16'h0000;
        bus.d_req   = 1'b0;
        bus.d_mode  = 3'd0;
        bus.d_addr  = 16'h0000;
        bus.d_wdata = 16'h0000;

        test_reset();
        test_fetch();
        test_priority();
        test_indirect_read();
        test_indirect_write();
        test_direct_write();
        test_noop();
        test_rdy_ignored();
        test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
